// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with the register-file write strobe produced in the DONE cycle.
module mul_div_unit #(
    parameter int unsigned address_width = 5,
    parameter int unsigned register_size = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [address_width-1:0] rd_in,
    input  logic [register_size-1:0] operand_a,
    input  logic [register_size-1:0] operand_b,
    output logic                     busy,
    output logic                     done,
    output logic [register_size-1:0] result,
    output logic [address_width-1:0] rd_out,
    output logic                     write_en
);

    localparam int unsigned W    = register_size;
    localparam int unsigned CntW = $clog2(register_size) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t                   stateQ, stateD;
    logic [CntW-1:0]          countQ, countD;
    logic [2*W-1:0]           accQ, accD;
    logic [W-1:0]             opndQ, opndD;
    logic [2:0]               opQ, opD;
    logic                     negQuoQ, negQuoD;
    logic                     negRemQ, negRemD;
    logic                     specialQ, specialD;
    logic [W-1:0]             resultQ, resultD;
    logic [address_width-1:0] rdQ, rdD;

    logic           aSigned, bSigned, aNeg, bNeg;
    logic [W-1:0]   magA, magB;
    logic [W:0]     mulSum, divTrial;
    logic [2*W-1:0] product;
    logic [W-1:0]   quotient, remainder;

    always_comb begin
        aSigned  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                   (funct3 == 3'b110);
        bSigned  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        aNeg     = aSigned && operand_a[W-1];
        bNeg     = bSigned && operand_b[W-1];
        magA     = aNeg ? -operand_a : operand_a;
        magB     = bNeg ? -operand_b : operand_b;
        // Multiply: accQ = {partial high, remaining multiplier bits}
        mulSum   = {1'b0, accQ[2*W-1:W]} + (accQ[0] ? {1'b0, opndQ} : {(W+1){1'b0}});
        // Divide: accQ = {partial remainder, remaining dividend / quotient bits}
        divTrial = accQ[2*W-1:W-1] - {1'b0, opndQ};
        product   = negQuoQ ? -accQ : accQ;
        quotient  = negQuoQ ? -accQ[W-1:0] : accQ[W-1:0];
        remainder = negRemQ ? -accQ[2*W-1:W] : accQ[2*W-1:W];
    end

    always_comb begin
        stateD   = stateQ;
        countD   = countQ;
        accD     = accQ;
        opndD    = opndQ;
        opD      = opQ;
        negQuoD  = negQuoQ;
        negRemD  = negRemQ;
        specialD = specialQ;
        resultD  = resultQ;
        rdD      = rdQ;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    stateD   = StCalc;
                    countD   = '0;
                    opD      = funct3;
                    rdD      = rd_in;
                    negQuoD  = aNeg ^ bNeg;
                    negRemD  = aNeg;
                    specialD = 1'b0;
                    if (funct3[2]) begin
                        accD  = {{W{1'b0}}, magA};
                        opndD = magB;
                        if (operand_b == '0) begin
                            specialD = 1'b1;
                            accD     = {{W{1'b0}}, (funct3[1] ? operand_a : {W{1'b1}})};
                        end else if (!funct3[0] && operand_a == {1'b1, {(W-1){1'b0}}} &&
                                     operand_b == {W{1'b1}}) begin
                            specialD = 1'b1;
                            accD     = {{W{1'b0}}, (funct3[1] ? {W{1'b0}} : operand_a)};
                        end
                    end else begin
                        accD  = {{W{1'b0}}, magB};
                        opndD = magA;
                    end
                end
            end
            StCalc: begin
                if (specialQ) begin
                    resultD = accQ[W-1:0];
                    stateD  = StDone;
                end else if (countQ == CntW'(W)) begin
                    unique case (opQ)
                        3'b000:                 resultD = product[W-1:0];
                        3'b001, 3'b010, 3'b011: resultD = product[2*W-1:W];
                        3'b100, 3'b101:         resultD = quotient;
                        default:                resultD = remainder;
                    endcase
                    stateD = StDone;
                end else begin
                    countD = countQ + CntW'(1);
                    if (opQ[2]) begin
                        accD = divTrial[W] ? {accQ[2*W-2:0], 1'b0}
                                           : {divTrial[W-1:0], accQ[W-2:0], 1'b1};
                    end else begin
                        accD = {mulSum, accQ[W-1:1]};
                    end
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stateQ   <= StIdle;
            countQ   <= '0;
            accQ     <= '0;
            opndQ    <= '0;
            opQ      <= '0;
            negQuoQ  <= 1'b0;
            negRemQ  <= 1'b0;
            specialQ <= 1'b0;
            resultQ  <= '0;
            rdQ      <= '0;
        end else begin
            stateQ   <= stateD;
            countQ   <= countD;
            accQ     <= accD;
            opndQ    <= opndD;
            opQ      <= opD;
            negQuoQ  <= negQuoD;
            negRemQ  <= negRemD;
            specialQ <= specialD;
            resultQ  <= resultD;
            rdQ      <= rdD;
        end
    end

    assign busy     = (stateQ != StIdle);
    assign done     = (stateQ == StDone);
    assign write_en = (stateQ == StDone) && (rdQ != '0);
    assign result   = resultQ;
    assign rd_out   = rdQ;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised scoreboard bench for mul_div_unit: driver pushes expected results, a negedge
// monitor pops and compares whenever done is presented.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd_in = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, write_en;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit prevDone = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          doneCyc;
    } exp_t;
    exp_t sb[$];

    mul_div_unit #(.address_width(5), .register_size(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3), .rd_in(rd_in),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out), .write_en(write_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Reference model from RV32M arithmetic rules.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, b);
        logic [63:0] p;
        int sa, sb2;
        sa = a;
        sb2 = b;
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb2;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                return sa % sb2;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, b, input logic [4:0] rd,
                         input bit track);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: busy=1 after %0d cycles, want 0", n);
        end
        start = 1'b1;
        funct3 = f;
        operand_a = a;
        operand_b = b;
        rd_in = rd;
        @(posedge clk);
        #1;
        if (track) begin
            e.res = ref_result(f, a, b);
            e.rd = rd;
            e.doneCyc = cyc + (is_special(f, a, b) ? 1 : 33);
            sb.push_back(e);
        end
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (prevDone) begin
                check("busy_after_done", {31'b0, busy}, 32'd0);
                check("done_single_pulse", {31'b0, done}, 32'd0);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 result=0x%08h want no done",
                             result);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
                    check("write_en", {31'b0, write_en}, {31'b0, (e.rd != 0)});
                    check("done_cycle", cyc, e.doneCyc);
                    check("busy_in_done", {31'b0, busy}, 32'd1);
                end
            end
        end
        prevDone = done;
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_we", {31'b0, write_en}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        issue(3'b000, 32'd7, 32'd6, 5'd5, 1);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 1);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1);
        issue(3'b100, -32'sd7, 32'd2, 5'd4, 1);
        issue(3'b110, -32'sd7, 32'd2, 5'd6, 1);
        issue(3'b101, 32'd100, 32'd7, 5'd7, 1);
        issue(3'b111, 32'd100, 32'd7, 5'd8, 1);
        issue(3'b100, 32'd5, 32'd0, 5'd9, 1);
        issue(3'b110, 32'd5, 32'd0, 5'd10, 1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1);
        issue(3'b000, 32'd9, 32'd9, 5'd0, 1);

        // Start pulses mid-CALC and during DONE must be ignored
        issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 1);
        repeat (10) @(negedge clk);
        start = 1'b1; funct3 = 3'b000; operand_a = 32'd1; operand_b = 32'd1; rd_in = 5'd20;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset aborts an operation in flight
        issue(3'b000, 32'd1000, 32'd1000, 5'd14, 0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(3'b000, 32'd3, 32'd3, 5'd15, 1);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = $urandom_range(0, 200);
                    b = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: ;
            endcase
            issue(f, a, b, 5'($urandom_range(0, 31)), 1);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
